// File: rtl/vga_scanout.sv
// VGA raster scanout: 640x480@60 timing, 1-bit pixel fetch from frame_buffer,
// and buffer-swap requests deferred to the start of vertical blanking.
module vga_scanout #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [18:0] read_addr,
  input  logic        read_data,
  input  logic        swap_request,
  output logic        swap,
  output logic        swap_done,
  output logic        frame_start,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic        vga_pixel
);

  localparam int unsigned CW        = 10;
  localparam int unsigned AW        = 19;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_FIRST  = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_LAST   = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST  = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_LAST   = VS_FIRST + V_SYNC - 1;
  localparam int unsigned ADDR_LAST = H_VISIBLE * V_VISIBLE - 1;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   h_cnt_q, h_cnt_d;
  logic [CW-1:0]   v_cnt_q, v_cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            de_q, de_d;
  logic            fs_q, fs_d;
  logic            swap_q, swap_d;

  logic h_last, v_last, visible, vblank_start;

  assign h_last       = (h_cnt_q == CW'(H_TOTAL - 1));
  assign v_last       = (v_cnt_q == CW'(V_TOTAL - 1));
  assign visible      = (h_cnt_q < CW'(H_VISIBLE)) && (v_cnt_q < CW'(V_VISIBLE));
  assign vblank_start = (h_cnt_q == '0) && (v_cnt_q == CW'(V_VISIBLE));

  // Raster counters, running fetch address and registered timing outputs
  always_comb begin
    h_cnt_d = h_cnt_q + CW'(1);
    v_cnt_d = v_cnt_q;
    addr_d  = addr_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + CW'(1);
    end
    // Address saturates on the last visible pixel so it stays in range through vblank
    if (h_last && v_last) begin
      addr_d = '0;
    end else if (visible && (addr_q != AW'(ADDR_LAST))) begin
      addr_d = addr_q + AW'(1);
    end
    hsync_d = !((h_cnt_q >= CW'(HS_FIRST)) && (h_cnt_q <= CW'(HS_LAST)));
    vsync_d = !((v_cnt_q >= CW'(VS_FIRST)) && (v_cnt_q <= CW'(VS_LAST)));
    de_d    = visible;
    fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Swap FSM: a request is only honoured on the first blanking line
  always_comb begin
    state_d = state_q;
    swap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_request) begin
          if (vblank_start) swap_d = 1'b1;
          else              state_d = PENDING;
        end
      end
      PENDING: begin
        if (!swap_request) begin
          state_d = IDLE;
        end else if (vblank_start) begin
          swap_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      swap_q  <= swap_d;
    end
  end

  assign read_addr   = addr_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;
  assign swap        = swap_q;
  assign swap_done   = swap_q;
  // read_data returns one clock after read_addr, matching the registered de
  assign vga_pixel   = de_q & read_data;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster: position-based reference model,
// random swap/reset stimulus, and literal timing pins.
module tb_vga_scanout;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 30
  localparam int VT = VV + VF + VS + VB;   // 19
  localparam int FRAME = HT * VT;          // 570
  localparam int NPIX = HV * VV;           // 192

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] read_addr;
  logic        read_data = 1'b0;
  logic        swap_request;
  logic        swap, swap_done, frame_start;
  logic        vga_hsync, vga_vsync, vga_de, vga_pixel;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_addr(read_addr), .read_data(read_data),
    .swap_request(swap_request), .swap(swap), .swap_done(swap_done),
    .frame_start(frame_start), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de), .vga_pixel(vga_pixel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Frame buffer contents: random bits, one-clock read latency
  bit mem [NPIX];
  initial for (int i = 0; i < NPIX; i++) mem[i] = 1'($urandom_range(0, 1));
  always @(posedge clk) read_data <= (read_addr < NPIX) ? mem[read_addr] : 1'b0;

  // Address the fetch counter must hold while the raster sits at position p
  function automatic int addr_of(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    if (h < HV && v < VV) return v * HV + h;
    if (v < VV - 1)       return (v + 1) * HV;
    return NPIX - 1;
  endfunction

  // Reference model: pos is the raster position the DUT counters hold now
  int   pos = 0;
  bit   model_valid = 0;
  logic e_hs, e_vs, e_de, e_fs, e_sw, e_pix;
  int   e_addr;

  always @(posedge clk) begin
    int h, v;
    model_valid = 1;
    if (!rst_n) begin
      pos = 0;
      e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_sw = 0; e_pix = 0;
    end else begin
      h = pos % HT;
      v = pos / HT;
      e_hs  = !(h >= HV + HF && h < HV + HF + HS);
      e_vs  = !(v >= VV + VF && v < VV + VF + VS);
      e_de  = (h < HV) && (v < VV);
      e_fs  = (pos == 0);
      e_sw  = swap_request && (pos == VV * HT);
      e_pix = e_de ? mem[v * HV + h] : 1'b0;
      pos   = (pos + 1) % FRAME;
    end
    e_addr = addr_of(pos);
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("hsync", 32'(vga_hsync), 32'(e_hs));
      chk("vsync", 32'(vga_vsync), 32'(e_vs));
      chk("de", 32'(vga_de), 32'(e_de));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("swap", 32'(swap), 32'(e_sw));
      chk("swap_done", 32'(swap_done), 32'(e_sw));
      chk("pixel", 32'(vga_pixel), 32'(e_pix));
      chk("read_addr", 32'(read_addr), 32'(e_addr));
    end
  end

  initial begin
    int hs_low, vs_low, max_addr, n_fs, n_sw, n;
    int fs_t [2];
    int sw_t [2];
    rst_n = 1'b0;
    swap_request = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_hsync", 32'(vga_hsync), 1);
    chk("reset_de", 32'(vga_de), 0);
    chk("reset_addr", 32'(read_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_de", 32'(vga_de), 1);
    chk("first_frame_start", 32'(frame_start), 1);
    chk("first_addr", 32'(read_addr), 1);

    // Two frames: sync widths, frame period, address range, held request
    hs_low = 0; vs_low = 0; max_addr = 0; n_fs = 0; n_sw = 0;
    fs_t[0] = -1; fs_t[1] = -1; sw_t[0] = -1; sw_t[1] = -1;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      if (i <= FRAME) begin
        if (!vga_hsync) hs_low++;
        if (!vga_vsync) vs_low++;
        if (int'(read_addr) > max_addr) max_addr = int'(read_addr);
      end
      if (i == FRAME - 1) chk("addr_wrap", 32'(read_addr), 0);
      if (frame_start) begin if (n_fs < 2) fs_t[n_fs] = i; n_fs++; end
      if (swap) begin if (n_sw < 2) sw_t[n_sw] = i; n_sw++; end
      if (i == 5 * HT) swap_request = 1'b1;
      if (swap && i > FRAME) swap_request = 1'b0;
    end
    chk("hsync_low_per_frame", 32'(hs_low), 6 * 19);
    chk("vsync_low_per_frame", 32'(vs_low), 2 * 30);
    chk("max_read_addr", 32'(max_addr), 191);
    chk("frame_start_count", 32'(n_fs), 2);
    chk("frame_period_1", 32'(fs_t[0]), 570);
    chk("frame_period_2", 32'(fs_t[1]), 1140);
    chk("swap_count", 32'(n_sw), 2);
    chk("swap_time_1", 32'(sw_t[0]), 360);
    chk("swap_time_2", 32'(sw_t[1]), 930);

    // Request present only on the vblank-start edge
    for (int i = 0; i < 2 * FRAME && pos != VV * HT; i++) @(negedge clk);
    swap_request = 1'b1;
    @(negedge clk);
    swap_request = 1'b0;
    chk("pulse_swap", 32'(swap), 1);

    // Mid-frame reset with a pending request
    for (int i = 0; i < 2 * FRAME && pos != 8 * HT; i++) @(negedge clk);
    swap_request = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_addr", 32'(read_addr), 0);
    chk("midreset_vsync", 32'(vga_vsync), 1);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      if (swap) begin n = i; break; end
    end
    chk("swap_after_reset", 32'(n), 361);
    swap_request = 1'b0;

    // Random request toggling with occasional reset pulses
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) swap_request = ~swap_request;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 3999) == 0) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
